// File: rtl/store_narrower_if.sv
// Store request / data-memory bundle for store_narrower.
// The master side is the MEM stage plus memory; the slave side is the narrowing unit.
interface store_narrower_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_valid;
    logic                  o_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_data;
    logic [1:0]            i_size;
    logic                  o_done;
    logic                  o_misaligned;
    logic [ADDR_WIDTH-3:0] o_mem_addr;
    logic                  o_mem_re;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  o_mem_we;
    logic [DATA_WIDTH-1:0] o_mem_wdata;

    modport master (
        output i_valid, i_addr, i_data, i_size, i_mem_rdata,
        input  o_ready, o_done, o_misaligned, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata
    );

    modport slave (
        input  i_valid, i_addr, i_data, i_size, i_mem_rdata,
        output o_ready, o_done, o_misaligned, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/store_narrower.sv
// Narrows a register value to SB/SH/SW and writes it to word memory, using read-modify-write
// for sub-word stores. Define STORE_NARROWER_BIG_ENDIAN_EN for big-endian lane mapping.
module store_narrower #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    store_narrower_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_ERROR} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_accept;
    logic [1:0]            w_blane;
    logic                  w_hsel;

    assign bus.o_ready = (r_state == S_IDLE) && i_reset;
    assign w_accept    = bus.i_valid && bus.o_ready;

`ifdef STORE_NARROWER_BIG_ENDIAN_EN
    assign w_blane = ~r_addr[1:0];
    assign w_hsel  = ~r_addr[1];
`else
    assign w_blane = r_addr[1:0];
    assign w_hsel  = r_addr[1];
`endif

    always_comb begin
        w_merged = bus.i_mem_rdata;
        case (r_size)
            2'b00:   w_merged[{w_blane, 3'b000} +: 8]  = r_data[7:0];
            2'b01:   w_merged[{w_hsel, 4'b0000} +: 16] = r_data[15:0];
            default: w_merged = r_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.i_size == 2'b10 && bus.i_addr[1:0] == 2'b00)
                        w_next = S_WRITE;
                    else if (bus.i_size == 2'b00 || (bus.i_size == 2'b01 && !bus.i_addr[0]))
                        w_next = S_READ;
                    else
                        w_next = S_ERROR;
                end
            end
            S_READ:  w_next = S_MERGE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Word stores skip the merge, so the latched value is already the write data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.i_addr;
            r_data  <= bus.i_data;
            r_size  <= bus.i_size;
            r_wdata <= bus.i_data;
        end else if (r_state == S_MERGE) begin
            r_wdata <= w_merged;
        end
    end

    always_comb begin
        bus.o_done       = 1'b0;
        bus.o_misaligned = 1'b0;
        bus.o_mem_re     = 1'b0;
        bus.o_mem_we     = 1'b0;
        bus.o_mem_wdata  = '0;
        bus.o_mem_addr   = '0;
        if (r_state != S_IDLE)
            bus.o_mem_addr = r_addr[ADDR_WIDTH-1:2];
        case (r_state)
            S_READ:  bus.o_mem_re = 1'b1;
            S_WRITE: begin
                bus.o_mem_we    = 1'b1;
                bus.o_done      = 1'b1;
                bus.o_mem_wdata = r_wdata;
            end
            S_ERROR: begin
                bus.o_done       = 1'b1;
                bus.o_misaligned = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
